// File: rtl/bus_cycle_pkg.sv
// Shared types and constants for the 8088 slave-side bus cycle controller.
// Cycle-type helpers keep the port routing decisions in one place.
package bus_cycle_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    INTA_W,
    HOLD
  } state_t;

  typedef enum logic [2:0] {
    CYC_MEM_RD,
    CYC_MEM_WR,
    CYC_IO_RD,
    CYC_IO_WR,
    CYC_INTA
  } cycle_t;

  localparam logic [7:0] IDLE_DATA = 8'hFF;

  function automatic logic cyc_is_io(input cycle_t c);
    return (c == CYC_IO_RD) || (c == CYC_IO_WR);
  endfunction

  function automatic logic cyc_is_wr(input cycle_t c);
    return (c == CYC_MEM_WR) || (c == CYC_IO_WR);
  endfunction

  function automatic logic cyc_is_rd(input cycle_t c);
    return (c == CYC_MEM_RD) || (c == CYC_IO_RD);
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state / timeout counter: cleared on cycle start, counts while enabled,
// saturates so a disabled timeout can never wrap back under MIN_WAIT.
module bus_wait_timer #(
  parameter int unsigned MIN_WAIT = 0,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TO_W     = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic min_done_o,
  output logic expired_o
);

  logic [TO_W-1:0] cnt_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else if (clr_i) begin
      cnt_reg <= '0;
    end else if (en_i && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + TO_W'(1);
    end
  end

  generate
    if (MIN_WAIT == 0) begin : g_no_min
      assign min_done_o = 1'b1;
    end else begin : g_min
      assign min_done_o = (cnt_reg >= TO_W'(MIN_WAIT));
    end

    if (TIMEOUT == 0) begin : g_no_timeout
      assign expired_o = 1'b0;
    end else begin : g_timeout
      assign expired_o = (cnt_reg == TO_W'(TIMEOUT));
    end
  endgenerate

endmodule

// File: rtl/bus_cycle_ctrl.sv
// Slave-side bus cycle controller for the 8088 multiplexed bus: latches the
// address on ALE, routes each cycle to the memory or IO port, and stalls READY.
module bus_cycle_ctrl
  import bus_cycle_pkg::*;
#(
  parameter int unsigned MIN_WAIT = 0,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TO_W     = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ale_i,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic        iom_i,
  input  logic        inta_i,
  input  logic [19:0] ad_i,
  output logic [7:0]  ad_o,
  output logic        ready_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [19:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_rdata_i,
  output logic        io_req_o,
  output logic        io_we_o,
  output logic [15:0] io_addr_o,
  output logic [7:0]  io_wdata_o,
  input  logic        io_ack_i,
  input  logic [7:0]  io_rdata_i,
  input  logic [7:0]  irq_vec_i,
  output logic        inta_ack_o,
  output logic        timeout_o,
  output logic        busy_o
);

  state_t      state_reg, state_next;
  cycle_t      cyc_reg, cyc_next;
  logic [19:0] addr_reg, addr_next;
  logic [7:0]  wdata_reg, wdata_next;
  logic [7:0]  ad_reg, ad_next;
  logic        req_reg, req_next;
  logic        ack_seen_reg, ack_seen_next;
  logic        ready_reg, ready_next;
  logic        phase_reg, phase_next;
  logic        inta_ack_reg, inta_ack_next;
  logic        timeout_reg, timeout_next;

  logic        tmr_clr, tmr_en, min_done, expired;
  logic        slave_ack;
  logic [7:0]  slave_rdata;

  bus_wait_timer #(
    .MIN_WAIT (MIN_WAIT),
    .TIMEOUT  (TIMEOUT),
    .TO_W     (TO_W)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (tmr_clr),
    .en_i       (tmr_en),
    .min_done_o (min_done),
    .expired_o  (expired)
  );

  assign tmr_en      = (state_reg == REQ) || (state_reg == INTA_W);
  assign slave_ack   = cyc_is_io(cyc_reg) ? io_ack_i : mem_ack_i;
  assign slave_rdata = cyc_is_io(cyc_reg) ? io_rdata_i : mem_rdata_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      cyc_reg      <= CYC_MEM_RD;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      ad_reg       <= IDLE_DATA;
      req_reg      <= 1'b0;
      ack_seen_reg <= 1'b0;
      ready_reg    <= 1'b1;
      phase_reg    <= 1'b0;
      inta_ack_reg <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cyc_reg      <= cyc_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      ad_reg       <= ad_next;
      req_reg      <= req_next;
      ack_seen_reg <= ack_seen_next;
      ready_reg    <= ready_next;
      phase_reg    <= phase_next;
      inta_ack_reg <= inta_ack_next;
      timeout_reg  <= timeout_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cyc_next      = cyc_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    ad_next       = ad_reg;
    req_next      = req_reg;
    ack_seen_next = ack_seen_reg;
    ready_next    = ready_reg;
    phase_next    = phase_reg;
    inta_ack_next = 1'b0;
    timeout_next  = 1'b0;
    tmr_clr       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (ale_i) addr_next = ad_i;
        // Read takes priority over a simultaneous write strobe.
        if (!rd_i || !wr_i) begin
          state_next    = REQ;
          ready_next    = 1'b0;
          req_next      = 1'b1;
          ack_seen_next = 1'b0;
          tmr_clr       = 1'b1;
          if (!rd_i) begin
            cyc_next = iom_i ? CYC_IO_RD : CYC_MEM_RD;
          end else begin
            cyc_next   = iom_i ? CYC_IO_WR : CYC_MEM_WR;
            wdata_next = ad_i[7:0];
          end
        end else if (!inta_i) begin
          state_next = INTA_W;
          ready_next = 1'b0;
          tmr_clr    = 1'b1;
          cyc_next   = CYC_INTA;
          ad_next    = phase_reg ? irq_vec_i : IDLE_DATA;
        end
      end
      REQ: begin
        if (!ack_seen_reg && slave_ack) begin
          ack_seen_next = 1'b1;
          req_next      = 1'b0;
          if (cyc_is_rd(cyc_reg)) ad_next = slave_rdata;
        end
        // Exit uses the registered ack so READY spans the ack cycle.
        if (ack_seen_reg && min_done) begin
          state_next = HOLD;
          ready_next = 1'b1;
        end else if (!ack_seen_reg && !slave_ack && expired) begin
          state_next   = HOLD;
          ready_next   = 1'b1;
          req_next     = 1'b0;
          ad_next      = IDLE_DATA;
          timeout_next = 1'b1;
        end
      end
      INTA_W: begin
        if (min_done) begin
          state_next    = HOLD;
          ready_next    = 1'b1;
          phase_next    = ~phase_reg;
          inta_ack_next = phase_reg;
        end
      end
      HOLD: begin
        if (rd_i && wr_i && inta_i) begin
          state_next = IDLE;
          ad_next    = IDLE_DATA;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ad_o        = ad_reg;
  assign ready_o     = ready_reg;
  assign mem_req_o   = req_reg && !cyc_is_io(cyc_reg);
  assign mem_we_o    = req_reg && !cyc_is_io(cyc_reg) && cyc_is_wr(cyc_reg);
  assign mem_addr_o  = addr_reg;
  assign mem_wdata_o = wdata_reg;
  assign io_req_o    = req_reg && cyc_is_io(cyc_reg);
  assign io_we_o     = req_reg && cyc_is_io(cyc_reg) && cyc_is_wr(cyc_reg);
  assign io_addr_o   = addr_reg[15:0];
  assign io_wdata_o  = wdata_reg;
  assign inta_ack_o  = inta_ack_reg;
  assign timeout_o   = timeout_reg;
  assign busy_o      = (state_reg != IDLE);

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Bench for bus_cycle_ctrl: two instances (MIN_WAIT=0/TIMEOUT=16 and
// MIN_WAIT=4/no timeout) driven as a CPU plus slave, checked against a cycle-count model.
module tb_bus_cycle_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ale [2];
  logic        rd [2];
  logic        wr [2];
  logic        iom [2];
  logic        inta [2];
  logic [19:0] ad_in [2];
  logic [7:0]  ad_out [2];
  logic        ready [2];
  logic        mem_req [2];
  logic        mem_we [2];
  logic [19:0] mem_addr [2];
  logic [7:0]  mem_wdata [2];
  logic        mem_ack [2];
  logic [7:0]  mem_rdata [2];
  logic        io_req [2];
  logic        io_we [2];
  logic [15:0] io_addr [2];
  logic [7:0]  io_wdata [2];
  logic        io_ack [2];
  logic [7:0]  io_rdata [2];
  logic [7:0]  irq_vec;
  logic        inta_ack [2];
  logic        timeout [2];
  logic        busy [2];

  int total = 0;
  int bad   = 0;
  int inta_cnt [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      bus_cycle_ctrl #(
        .MIN_WAIT ((gi == 0) ? 0 : 4),
        .TIMEOUT  ((gi == 0) ? 16 : 0),
        .TO_W     (8)
      ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ale_i       (ale[gi]),
        .rd_i        (rd[gi]),
        .wr_i        (wr[gi]),
        .iom_i       (iom[gi]),
        .inta_i      (inta[gi]),
        .ad_i        (ad_in[gi]),
        .ad_o        (ad_out[gi]),
        .ready_o     (ready[gi]),
        .mem_req_o   (mem_req[gi]),
        .mem_we_o    (mem_we[gi]),
        .mem_addr_o  (mem_addr[gi]),
        .mem_wdata_o (mem_wdata[gi]),
        .mem_ack_i   (mem_ack[gi]),
        .mem_rdata_i (mem_rdata[gi]),
        .io_req_o    (io_req[gi]),
        .io_we_o     (io_we[gi]),
        .io_addr_o   (io_addr[gi]),
        .io_wdata_o  (io_wdata[gi]),
        .io_ack_i    (io_ack[gi]),
        .io_rdata_i  (io_rdata[gi]),
        .irq_vec_i   (irq_vec),
        .inta_ack_o  (inta_ack[gi]),
        .timeout_o   (timeout[gi]),
        .busy_o      (busy[gi])
      );
    end
  endgenerate

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // kind: 0 read, 1 write, 2 read+write strobes, 3 interrupt acknowledge.
  // ack_k: REQ cycle (1-based) in which the slave acks; 0 means never.
  task automatic run_cycle(input int d, input int kind, input logic io, input logic [19:0] addr,
                           input logic [7:0] data, input int ack_k, input logic [7:0] rdata);
    int mw, to, exp_low, low, req_last, req_bad, to_cnt, ia_cnt;
    logic is_rd, is_inta, aborted, done, exp_mreq, exp_ireq, exp_iack;
    logic [7:0] exp_ad;
    mw      = (d == 0) ? 0 : 4;
    to      = (d == 0) ? 16 : 0;
    is_inta = (kind == 3);
    is_rd   = (kind == 0) || (kind == 2);
    aborted = !is_inta && ((ack_k == 0) || (to != 0 && ack_k > to + 1));
    exp_iack = is_inta && (inta_cnt[d] % 2 == 1);
    if (is_inta) begin
      exp_low  = mw + 1;
      exp_ad   = (inta_cnt[d] % 2 == 1) ? irq_vec : 8'hFF;
      req_last = 0;
    end else if (aborted) begin
      exp_low  = to + 1;
      exp_ad   = 8'hFF;
      req_last = exp_low;
    end else begin
      exp_low  = (ack_k > mw) ? ack_k + 1 : mw + 1;
      exp_ad   = is_rd ? rdata : 8'hFF;
      req_last = ack_k;
    end

    @(negedge clk);
    ale[d] = 1'b1; ad_in[d] = ~addr; iom[d] = io;
    @(negedge clk);
    ad_in[d] = addr;
    @(negedge clk);
    ale[d] = 1'b0; ad_in[d] = {addr[19:8], data};
    if (is_inta) inta[d] = 1'b0;
    else begin
      if (kind != 1) rd[d] = 1'b0;
      if (kind != 0) wr[d] = 1'b0;
    end
    mem_rdata[d] = io ? ~rdata : rdata;
    io_rdata[d]  = io ? rdata : ~rdata;

    low = 0; done = 1'b0; req_bad = 0; to_cnt = 0; ia_cnt = 0;
    for (int c = 1; c <= 400 && !done; c++) begin
      @(negedge clk);
      mem_ack[d] = 1'b0; io_ack[d] = 1'b0;
      exp_mreq = !io && (c <= req_last);
      exp_ireq = io && (c <= req_last);
      if (mem_req[d] !== exp_mreq || io_req[d] !== exp_ireq) req_bad++;
      to_cnt += int'(timeout[d]);
      ia_cnt += int'(inta_ack[d]);
      if (ready[d]) done = 1'b1;
      else low++;
      if (c == 1) begin
        if (is_inta) check_val("inta_entry_ad", ad_out[d], exp_ad);
        else if (io) begin
          check_val("io_addr", io_addr[d], addr[15:0]);
          check_val("io_we", io_we[d], kind == 1);
          if (kind == 1) check_val("io_wdata", io_wdata[d], data);
        end else begin
          check_val("mem_addr", mem_addr[d], addr);
          check_val("mem_we", mem_we[d], kind == 1);
          if (kind == 1) check_val("mem_wdata", mem_wdata[d], data);
        end
      end
      if (!is_inta && c == ack_k) begin
        if (io) io_ack[d] = 1'b1;
        else mem_ack[d] = 1'b1;
      end
    end

    check_val("ready_return", done, 1'b1);
    check_val("ready_low_cycles", low, exp_low);
    check_val("hold_ad", ad_out[d], exp_ad);
    check_val("req_pattern_errs", req_bad, 0);
    check_val("timeout_pulses", to_cnt, aborted);
    check_val("inta_ack_pulses", ia_cnt, exp_iack);
    check_val("hold_busy", busy[d], 1'b1);
    if (aborted) begin
      mem_rdata[d] = 8'hAA; io_rdata[d] = 8'hAA;
      if (io) io_ack[d] = 1'b1;
      else mem_ack[d] = 1'b1;
    end
    @(negedge clk);
    mem_ack[d] = 1'b0; io_ack[d] = 1'b0;
    check_val("hold_ad_stable", ad_out[d], exp_ad);
    check_val("hold_ready", ready[d], 1'b1);
    check_val("pulse_width", {timeout[d], inta_ack[d], mem_req[d], io_req[d]}, 4'b0);
    rd[d] = 1'b1; wr[d] = 1'b1; inta[d] = 1'b1;
    @(negedge clk);
    check_val("idle_ad", ad_out[d], 8'hFF);
    check_val("idle_busy", busy[d], 1'b0);
    if (is_inta) inta_cnt[d]++;
    $display("txn dut=%0d kind=%0d io=%0d addr=%05h ack=%0d low=%0d exp_low=%0d ad=%02h",
             d, kind, io, addr, ack_k, low, exp_low, exp_ad);
  endtask

  initial begin
    rst = 1'b0;
    irq_vec = 8'h08;
    for (int d = 0; d < 2; d++) begin
      ale[d] = 1'b0; rd[d] = 1'b1; wr[d] = 1'b1; iom[d] = 1'b0; inta[d] = 1'b1;
      ad_in[d] = '0; mem_ack[d] = 1'b0; io_ack[d] = 1'b0;
      mem_rdata[d] = '0; io_rdata[d] = '0; inta_cnt[d] = 0;
    end
    #1 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_val("rst_ready", ready[d], 1'b1);
      check_val("rst_ad", ad_out[d], 8'hFF);
      check_val("rst_reqs", {mem_req[d], io_req[d], mem_we[d], io_we[d]}, 4'b0);
      check_val("rst_pulses", {inta_ack[d], timeout[d], busy[d]}, 3'b0);
      check_val("rst_addr", mem_addr[d], 20'h0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_cycle(0, 0, 1'b0, 20'hFFFF0, 8'h00, 3, 8'hEA);   // memory read, late ack
    run_cycle(0, 1, 1'b1, 20'h003F8, 8'h55, 1, 8'h00);   // IO write, immediate ack
    run_cycle(1, 0, 1'b0, 20'h12345, 8'h00, 1, 8'h3C);   // MIN_WAIT=4, immediate ack
    run_cycle(1, 3, 1'b0, 20'h00000, 8'h00, 1, 8'h00);   // INTA pair
    run_cycle(1, 3, 1'b0, 20'h00000, 8'h00, 1, 8'h00);
    run_cycle(0, 0, 1'b0, 20'h40000, 8'h00, 0, 8'h11);   // timeout
    run_cycle(0, 0, 1'b0, 20'h40001, 8'h00, 2, 8'h77);   // normal after abort
    run_cycle(0, 2, 1'b1, 20'h00060, 8'h99, 17, 8'h5A);  // ack in last legal cycle
    run_cycle(0, 1, 1'b0, 20'h00061, 8'h66, 18, 8'h00);  // ack one cycle too late

    // asynchronous reset in the middle of a REQ
    @(negedge clk);
    ale[0] = 1'b1; ad_in[0] = 20'h2468A; iom[0] = 1'b0;
    @(negedge clk);
    ale[0] = 1'b0; rd[0] = 1'b0;
    repeat (5) @(negedge clk);
    check_val("pre_rst_req", mem_req[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    check_val("midrst_mem_req", mem_req[0], 1'b0);
    check_val("midrst_ready", ready[0], 1'b1);
    check_val("midrst_ad", ad_out[0], 8'hFF);
    check_val("midrst_busy", busy[0], 1'b0);
    @(negedge clk);
    rst = 1'b0; rd[0] = 1'b1;
    inta_cnt[0] = 0; inta_cnt[1] = 0;
    run_cycle(0, 3, 1'b0, 20'h00000, 8'h00, 1, 8'h00);
    run_cycle(0, 3, 1'b0, 20'h00000, 8'h00, 1, 8'h00);

    for (int n = 0; n < 40; n++) begin
      int d, kind, k;
      d    = $urandom_range(0, 1);
      kind = $urandom_range(0, 3);
      k    = $urandom_range(1, 6);
      if (d == 0 && $urandom_range(0, 7) == 0) k = 0;
      run_cycle(d, kind, 1'($urandom), 20'($urandom), 8'($urandom), k, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
